// File: rtl/angle_uart_tx.sv
// UART 8N1 transmitter for filtered roll/pitch/yaw angles.
// Sends an 8-byte frame: sync, six angle bytes (MSB first), 8-bit sum checksum.
module angle_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 87,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] roll_in,
  input  logic [15:0] pitch_in,
  input  logic [15:0] yaw_in,
  input  logic        angle_valid,
  output logic        tx,
  output logic        busy,
  output logic        frame_done,
  output logic        overrun,
  output logic [7:0]  overrun_cnt
);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  localparam logic [15:0] BAUD_LAST = 16'(CLKS_PER_BIT - 1);

  state_t      state_q, state_d;
  logic [15:0] baud_cnt_q, baud_cnt_d;
  logic [2:0]  bit_idx_q, bit_idx_d;
  logic [2:0]  byte_idx_q, byte_idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [47:0] angles_q, angles_d;
  logic [7:0]  csum_q, csum_d;
  logic        tx_q, tx_d;
  logic        busy_q, busy_d;
  logic        frame_done_q, frame_done_d;
  logic        overrun_q, overrun_d;
  logic [7:0]  overrun_cnt_q, overrun_cnt_d;

  logic        baud_end;
  logic [2:0]  byte_nxt;
  logic [7:0]  next_byte;
  logic [7:0]  csum_in;

  assign baud_end = (baud_cnt_q == BAUD_LAST);
  assign byte_nxt = byte_idx_q + 3'd1;
  assign csum_in  = roll_in[15:8] + roll_in[7:0] + pitch_in[15:8] + pitch_in[7:0]
                  + yaw_in[15:8] + yaw_in[7:0];

  always_comb begin
    case (byte_nxt)
      3'd1:    next_byte = angles_q[47:40];
      3'd2:    next_byte = angles_q[39:32];
      3'd3:    next_byte = angles_q[31:24];
      3'd4:    next_byte = angles_q[23:16];
      3'd5:    next_byte = angles_q[15:8];
      3'd6:    next_byte = angles_q[7:0];
      3'd7:    next_byte = csum_q;
      default: next_byte = SYNC_BYTE;
    endcase
  end

  always_comb begin
    state_d       = state_q;
    baud_cnt_d    = baud_cnt_q;
    bit_idx_d     = bit_idx_q;
    byte_idx_d    = byte_idx_q;
    shift_d       = shift_q;
    angles_d      = angles_q;
    csum_d        = csum_q;
    tx_d          = tx_q;
    busy_d        = busy_q;
    frame_done_d  = 1'b0;
    overrun_d     = 1'b0;
    overrun_cnt_d = overrun_cnt_q;

    if (angle_valid && (state_q != IDLE)) begin
      overrun_d = 1'b1;
      if (overrun_cnt_q != 8'hFF) overrun_cnt_d = overrun_cnt_q + 8'd1;
    end

    case (state_q)
      IDLE: begin
        if (angle_valid) begin
          state_d    = START;
          angles_d   = {roll_in, pitch_in, yaw_in};
          csum_d     = csum_in;
          shift_d    = SYNC_BYTE;
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
          byte_idx_d = 3'd0;
          tx_d       = 1'b0;
          busy_d     = 1'b1;
        end
      end
      START: begin
        if (baud_end) begin
          baud_cnt_d = 16'd0;
          bit_idx_d  = 3'd0;
          state_d    = DATA;
          tx_d       = shift_q[0];
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      DATA: begin
        if (baud_end) begin
          baud_cnt_d = 16'd0;
          if (bit_idx_q == 3'd7) begin
            state_d = STOP;
            tx_d    = 1'b1;
          end else begin
            bit_idx_d = bit_idx_q + 3'd1;
            shift_d   = {1'b0, shift_q[7:1]};
            tx_d      = shift_q[1];
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      STOP: begin
        if (baud_end) begin
          baud_cnt_d = 16'd0;
          if (byte_idx_q == 3'd7) begin
            state_d      = IDLE;
            busy_d       = 1'b0;
            frame_done_d = 1'b1;
          end else begin
            // Next byte starts immediately; no idle gap inside a frame.
            byte_idx_d = byte_nxt;
            shift_d    = next_byte;
            state_d    = START;
            tx_d       = 1'b0;
          end
        end else begin
          baud_cnt_d = baud_cnt_q + 16'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      baud_cnt_q    <= 16'd0;
      bit_idx_q     <= 3'd0;
      byte_idx_q    <= 3'd0;
      shift_q       <= 8'd0;
      angles_q      <= 48'd0;
      csum_q        <= 8'd0;
      tx_q          <= 1'b1;
      busy_q        <= 1'b0;
      frame_done_q  <= 1'b0;
      overrun_q     <= 1'b0;
      overrun_cnt_q <= 8'd0;
    end else begin
      state_q       <= state_d;
      baud_cnt_q    <= baud_cnt_d;
      bit_idx_q     <= bit_idx_d;
      byte_idx_q    <= byte_idx_d;
      shift_q       <= shift_d;
      angles_q      <= angles_d;
      csum_q        <= csum_d;
      tx_q          <= tx_d;
      busy_q        <= busy_d;
      frame_done_q  <= frame_done_d;
      overrun_q     <= overrun_d;
      overrun_cnt_q <= overrun_cnt_d;
    end
  end

  assign tx          = tx_q;
  assign busy        = busy_q;
  assign frame_done  = frame_done_q;
  assign overrun     = overrun_q;
  assign overrun_cnt = overrun_cnt_q;
endmodule

// File: tb/tb_angle_uart_tx.sv
// Bench for angle_uart_tx: decodes the serial line sample by sample and
// compares against frames built from the angle values with plain arithmetic.
module tb_angle_uart_tx;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] roll_in = '0, pitch_in = '0, yaw_in = '0;
  logic        angle_valid = 1'b0;
  logic        sel = 1'b0;
  logic        av4, av87;
  logic        tx4, busy4, fd4, ov4, tx87, busy87, fd87, ov87;
  logic [7:0]  cnt4, cnt87;
  logic        tx_m, busy_m, fd_m, ov_m;
  logic [7:0]  cnt_m;

  int total = 0;
  int bad = 0;
  int cpb = 4;
  int ov_model[2] = '{0, 0};
  logic [7:0] got[8];

  always #5 clk = ~clk;

  assign av4    = angle_valid & ~sel;
  assign av87   = angle_valid & sel;
  assign tx_m   = sel ? tx87 : tx4;
  assign busy_m = sel ? busy87 : busy4;
  assign fd_m   = sel ? fd87 : fd4;
  assign ov_m   = sel ? ov87 : ov4;
  assign cnt_m  = sel ? cnt87 : cnt4;

  angle_uart_tx #(.CLKS_PER_BIT(4), .SYNC_BYTE(8'hA5)) dut4 (
    .clk(clk), .rst(rst), .roll_in(roll_in), .pitch_in(pitch_in), .yaw_in(yaw_in),
    .angle_valid(av4), .tx(tx4), .busy(busy4), .frame_done(fd4), .overrun(ov4),
    .overrun_cnt(cnt4));

  angle_uart_tx #(.CLKS_PER_BIT(87), .SYNC_BYTE(8'hA5)) dut87 (
    .clk(clk), .rst(rst), .roll_in(roll_in), .pitch_in(pitch_in), .yaw_in(yaw_in),
    .angle_valid(av87), .tx(tx87), .busy(busy87), .frame_done(fd87), .overrun(ov87),
    .overrun_cnt(cnt87));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  // Sample 0 is the negedge right after the accept edge; sample 80*cpb is the
  // negedge after busy should have dropped.
  task automatic run_frame(input logic [15:0] r, input logic [15:0] p, input logic [15:0] y,
                           input bit started, input int s_lo, input int s_hi, input int s_step,
                           input bit chain, input logic [15:0] nr, input logic [15:0] np,
                           input logic [15:0] ny);
    logic [7:0] exp_b[8];
    logic samp[$];
    int len, n_busy, n_fd, n_ov, n_strobe, n_width, n_frm, sum;
    logic t, b, fd, ov, t_end, b_end, fd_end, bv;
    logic [7:0] v;
    len = 80 * cpb;
    n_busy = 0; n_fd = 0; n_ov = 0; n_strobe = 0; n_width = 0; n_frm = 0;
    t_end = 1'b0; b_end = 1'b1; fd_end = 1'b0;
    exp_b[0] = 8'hA5;
    exp_b[1] = r[15:8]; exp_b[2] = r[7:0];
    exp_b[3] = p[15:8]; exp_b[4] = p[7:0];
    exp_b[5] = y[15:8]; exp_b[6] = y[7:0];
    sum = 0;
    for (int k = 1; k <= 6; k++) sum += int'(exp_b[k]);
    exp_b[7] = 8'(sum % 256);

    if (!started) begin
      @(negedge clk);
      roll_in = r; pitch_in = p; yaw_in = y; angle_valid = 1'b1;
      @(negedge clk);
      angle_valid = 1'b0;
    end
    roll_in = 16'($urandom); pitch_in = 16'($urandom); yaw_in = 16'($urandom);

    for (int i = 0; i <= len; i++) begin
      if (i > 0) @(negedge clk);
      t = tx_m; b = busy_m; fd = fd_m; ov = ov_m;
      angle_valid = 1'b0;
      if (ov) n_ov++;
      if (b) n_busy++;
      if (fd) n_fd++;
      if (i < len) samp.push_back(t);
      else begin t_end = t; b_end = b; fd_end = fd; end
      if (i < len && s_step > 0 && i >= s_lo && i <= s_hi && ((i - s_lo) % s_step) == 0) begin
        angle_valid = 1'b1;
        n_strobe++;
        roll_in = 16'($urandom); pitch_in = 16'($urandom); yaw_in = 16'($urandom);
      end
      if (i == len && chain) begin
        roll_in = nr; pitch_in = np; yaw_in = ny; angle_valid = 1'b1;
      end
    end

    for (int k = 0; k < 8; k++) begin
      v = 8'h00;
      for (int j = 0; j < 10; j++) begin
        bv = samp[(k * 10 + j) * cpb];
        for (int m = 1; m < cpb; m++)
          if (samp[(k * 10 + j) * cpb + m] !== bv) n_width++;
        if (j == 0 && bv !== 1'b0) n_frm++;
        if (j == 9 && bv !== 1'b1) n_frm++;
        if (j >= 1 && j <= 8) v[j - 1] = bv;
      end
      got[k] = v;
      chk($sformatf("byte%0d", k), {24'd0, v}, {24'd0, exp_b[k]});
    end
    chk("bit_width_errors", n_width, 0);
    chk("framing_errors", n_frm, 0);
    chk("busy_cycles", n_busy, len);
    chk("busy_low_at_end", {31'd0, b_end}, 0);
    chk("frame_done_pulses", n_fd, 1);
    chk("frame_done_at_end", {31'd0, fd_end}, 1);
    chk("tx_idle_at_end", {31'd0, t_end}, 1);
    chk("overrun_pulses", n_ov, n_strobe);
    ov_model[sel] = (ov_model[sel] + n_strobe > 255) ? 255 : ov_model[sel] + n_strobe;
    chk("overrun_cnt", {24'd0, cnt_m}, ov_model[sel]);

    if (chain) begin
      @(negedge clk);
      angle_valid = 1'b0;
      chk("chain_start_bit", {31'd0, tx_m}, 0);
      chk("chain_busy", {31'd0, busy_m}, 1);
    end
  endtask

  typedef struct {
    logic [15:0] r, p, y;
    logic [7:0]  csum;
  } vec_t;

  initial begin
    vec_t vt[3];
    int lows, lo, st;
    vt[0] = '{r: 16'h002D, p: 16'hFFA5, y: 16'hF8CC, csum: 8'h95};
    vt[1] = '{r: 16'h0000, p: 16'h0000, y: 16'h0000, csum: 8'h00};
    vt[2] = '{r: 16'hFFFF, p: 16'hFFFF, y: 16'hFFFF, csum: 8'hFA};

    repeat (3) @(negedge clk);
    chk("reset_tx", {31'd0, tx4}, 1);
    chk("reset_busy", {31'd0, busy4}, 0);
    chk("reset_frame_done", {31'd0, fd4}, 0);
    chk("reset_overrun_cnt", {24'd0, cnt4}, 0);
    rst = 1'b0;

    // Reset in byte 3, data bit 5 (pitch high byte is zero, so tx is low there).
    @(negedge clk);
    roll_in = 16'h1234; pitch_in = 16'h0000; yaw_in = 16'h5678; angle_valid = 1'b1;
    @(negedge clk);
    angle_valid = 1'b0;
    repeat (146) @(negedge clk);
    chk("pre_reset_tx_low", {31'd0, tx4}, 0);
    #1 rst = 1'b1;
    #1;
    chk("async_reset_tx", {31'd0, tx4}, 1);
    chk("async_reset_busy", {31'd0, busy4}, 0);
    @(negedge clk);
    rst = 1'b0;
    ov_model = '{0, 0};
    lows = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (tx4 !== 1'b1 || busy4 !== 1'b0) lows++;
    end
    chk("no_resume_after_reset", lows, 0);

    for (int i = 0; i < 3; i++) begin
      run_frame(vt[i].r, vt[i].p, vt[i].y, 1'b0, 0, 0, 0, 1'b0, 16'h0, 16'h0, 16'h0);
      chk($sformatf("table_csum%0d", i), {24'd0, got[7]}, {24'd0, vt[i].csum});
      repeat (2) @(negedge clk);
    end

    // Strobes at frame cycles 10 and 100 are dropped.
    run_frame(16'hBEEF, 16'h0102, 16'h7F80, 1'b0, 10, 100, 90, 1'b0, 16'h0, 16'h0, 16'h0);
    repeat (3) @(negedge clk);

    // Strobe with frame_done, then a flood that saturates the counter.
    run_frame(16'h1111, 16'h2222, 16'h3333, 1'b0, 0, 0, 0, 1'b1, 16'hA0B1, 16'hC2D3, 16'hE4F5);
    run_frame(16'hA0B1, 16'hC2D3, 16'hE4F5, 1'b1, 1, 300, 1, 1'b0, 16'h0, 16'h0, 16'h0);
    chk("overrun_saturated", {24'd0, cnt4}, 255);
    repeat (2) @(negedge clk);

    for (int n = 0; n < 4; n++) begin
      lo = $urandom_range(1, 300);
      st = $urandom_range(1, 60);
      run_frame(16'($urandom), 16'($urandom), 16'($urandom), 1'b0, lo, 80 * cpb - 1, st,
                1'b0, 16'h0, 16'h0, 16'h0);
      repeat ($urandom_range(1, 5)) @(negedge clk);
    end

    sel = 1'b1;
    cpb = 87;
    run_frame(16'h002D, 16'hFFA5, 16'hF8CC, 1'b0, 0, 0, 0, 1'b0, 16'h0, 16'h0, 16'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
